// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline memory stage.
package arm_pipe_pkg;

    // Native datapath and register-address widths of the core.
    localparam int unsigned XLEN        = 32;
    localparam int unsigned RLEN        = 4;
    // Default number of WAIT cycles before a data-bus access is abandoned.
    localparam int unsigned BUS_TIMEOUT = 64;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_e;

    // EX/MEM pipeline register; control bits are already qualified by valid.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_to_reg;
        logic            mem_write;
        logic            pc_src;
        logic [RLEN-1:0] wa3;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
    } ex_mem_t;

    // MEM/WB pipeline register.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_to_reg;
        logic            pc_src;
        logic [RLEN-1:0] wa3;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] read_data;
    } mem_wb_t;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: tracks an outstanding req/ack access, counts wait
// cycles, aborts a stuck access and raises a sticky bus error.
module dmem_access_fsm
    import arm_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT
) (
    input  logic Clk,
    input  logic reset,
    input  logic memop,
    input  logic MemAck,
    output logic StallM,
    output logic abort,
    output logic BusErr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e       state;
    logic [CNT_W-1:0] count;
    logic             timeout;

    // An ack arriving on the timeout cycle still completes the access.
    assign timeout = (state == WAIT) && (count == CNT_W'(TIMEOUT_CYCLES));
    assign abort   = memop && !MemAck && timeout;
    assign StallM  = memop && !MemAck && !abort;

    // Access state, wait counter and sticky error flag.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            BusErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop && !MemAck) begin
                        state <= WAIT;
                        count <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!memop || MemAck) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (timeout) begin
                        state  <= IDLE;
                        count  <= '0;
                        BusErr <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data-bus access with variable latency, MEM/WB register.
// DATA_W/REG_W must match the package widths carried by the pipeline structs.
module mem_stage
    import arm_pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = XLEN,
    parameter int unsigned REG_W          = RLEN,
    parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              ValidE,
    input  logic              RegWriteE,
    input  logic              MemToRegE,
    input  logic              MemWriteE,
    input  logic              PCSrcE,
    input  logic [REG_W-1:0]  WA3E,
    input  logic [DATA_W-1:0] ALUResultE,
    input  logic [DATA_W-1:0] WriteDataE,
    output logic              StallM,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [REG_W-1:0]  WA3M,
    output logic              RegWriteM,
    output logic              MemReq,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic              PCSrcW,
    output logic [REG_W-1:0]  WA3W,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic              BusErr
);

    ex_mem_t exm;
    mem_wb_t mwb;
    mem_wb_t mwb_next;
    logic    memop;
    logic    abort;
    logic    load_done;

    assign memop     = exm.valid && (exm.mem_to_reg || exm.mem_write);
    assign load_done = memop && MemAck && exm.mem_to_reg && !exm.mem_write;

    dmem_access_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .Clk    (Clk),
        .reset  (reset),
        .memop  (memop),
        .MemAck (MemAck),
        .StallM (StallM),
        .abort  (abort),
        .BusErr (BusErr)
    );

    // EX/MEM register: capture EX results unless the current access is stalled.
    always_ff @(posedge Clk) begin
        if (reset) begin
            exm <= '0;
        end else if (!StallM) begin
            exm.valid      <= ValidE;
            exm.reg_write  <= ValidE & RegWriteE;
            exm.mem_to_reg <= ValidE & MemToRegE;
            exm.mem_write  <= ValidE & MemWriteE;
            exm.pc_src     <= ValidE & PCSrcE;
            exm.wa3        <= WA3E;
            exm.alu_result <= ALUResultE;
            exm.write_data <= WriteDataE;
        end
    end

    // MEM/WB next value: bubble while stalled, otherwise the retiring instruction.
    always_comb begin
        mwb_next = '0;
        if (!StallM) begin
            mwb_next.valid      = exm.valid;
            mwb_next.reg_write  = exm.reg_write && !abort;
            mwb_next.mem_to_reg = exm.mem_to_reg;
            mwb_next.pc_src     = exm.pc_src;
            mwb_next.wa3        = exm.wa3;
            mwb_next.alu_out    = exm.alu_result;
            mwb_next.read_data  = load_done ? MemRData : '0;
        end
    end

    // MEM/WB register: loaded every cycle.
    always_ff @(posedge Clk) begin
        if (reset) begin
            mwb <= '0;
        end else begin
            mwb <= mwb_next;
        end
    end

    assign ALUOutM   = exm.alu_result;
    assign WA3M      = exm.wa3;
    assign RegWriteM = exm.reg_write;
    assign MemReq    = memop;
    assign MemWe     = exm.mem_write;
    assign MemAddr   = exm.alu_result;
    assign MemWData  = exm.write_data;

    assign ValidW    = mwb.valid;
    assign RegWriteW = mwb.reg_write;
    assign MemToRegW = mwb.mem_to_reg;
    assign PCSrcW    = mwb.pc_src;
    assign WA3W      = mwb.wa3;
    assign ALUOutW   = mwb.alu_out;
    assign ReadDataW = mwb.read_data;

endmodule
